multi_edge_detector: RTL and testbench
======================================

MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 Parameter N_CH, 4, number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, 2, synchronizer flop depth per channel (>=2).
REQ-003 Parameter DEB_CYCLES, 4, consecutive stable cycles required to accept a new level (1..2^16-1).
REQ-004 Parameter COUNT_W, 8, width of per-channel edge counter.
REQ-005 Parameter RST_LEVEL, 1'b1, filtered level and synchronizer contents after reset.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset; assertion immediate, deassertion synchronous to clk by the integrator.
REQ-008 din  input  N_CH  raw asynchronous channel inputs.
REQ-009 mode  input  2*N_CH  per-channel edge mode, channel i at [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
REQ-010 clr  input  N_CH  per-channel one-cycle clear of pending flag and edge counter.
REQ-011 irq_en  input  N_CH  per-channel interrupt enable.
REQ-012 level  output  N_CH  debounced channel level.
REQ-013 edge_pulse  output  N_CH  one-cycle pulse per qualifying edge.
REQ-014 pending  output  N_CH  sticky qualifying-edge flag.
REQ-015 edge_cnt  output  N_CH*COUNT_W  per-channel qualifying-edge count, channel i at [(i+1)*COUNT_W-1 : i*COUNT_W].
REQ-016 irq  output  1  registered OR over i of (pending[i] & irq_en[i]).

Function
REQ-017 Each channel SHALL pass din[i] through SYNC_STAGES flops; only the last stage feeds the filter.
REQ-018 Filter counter SHALL increment each cycle the synchronized value differs from level[i] and reset to 0 on any cycle they match.
REQ-019 When the counter equals DEB_CYCLES-1 and the mismatch persists, level[i] SHALL take the synchronized value on that edge and the counter SHALL return to 0.
REQ-020 A glitch shorter than DEB_CYCLES cycles at synchronizer output SHALL NOT change level[i] or produce any event.
REQ-021 A level change SHALL qualify if mode is 01 and 0->1, 10 and 1->0, or 11 for either direction; mode 00 never qualifies but level[i] still tracks.
REQ-022 edge_pulse[i] SHALL be registered, high exactly the cycle level[i] first shows its new value, and low otherwise.
REQ-023 End-to-end latency: edge_pulse[i] rises SYNC_STAGES+DEB_CYCLES clock edges after the first edge sampling a stable new din[i].
REQ-024 mode SHALL be sampled on the same edge that updates level[i]; mode changes cause no pulse by themselves.
REQ-025 pending[i] SHALL set on a qualifying edge and clear on clr[i]; simultaneous set and clr SHALL leave pending[i]=1.
REQ-026 edge_cnt[i] SHALL increment on each qualifying edge and saturate at all-ones (no wrap).
REQ-027 clr[i] SHALL zero edge_cnt[i]; simultaneous clr and qualifying edge SHALL yield edge_cnt[i]=1.
REQ-028 irq SHALL update one cycle after pending/irq_en change.
REQ-029 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be reported in the same cycle.

Reset
REQ-030 On rst low: synchronizer flops and level = RST_LEVEL replicated; filter counters, edge_pulse, pending, edge_cnt, irq = 0.
REQ-031 No edge SHALL be reported after reset release unless din differs from RST_LEVEL for the full filter period.
REQ-032 Reset asserted mid-filter SHALL discard the partial count.

Structure
REQ-033 Package edge_pkg SHALL hold typedef enum logic[1:0] edge_mode_e {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH} and the default parameter constants.
REQ-034 Per-channel logic SHALL live in sub-module edge_ch, generated N_CH times; top holds only irq and port packing.

Verification (N_CH=4, SYNC_STAGES=2, DEB_CYCLES=4, COUNT_W=8, RST_LEVEL=1)
REQ-035 din[0] 1->0 held 10 cycles, mode0=10 -> edge_pulse[0] single pulse 6 edges later, pending[0]=1, edge_cnt0=1.
REQ-036 din[1] low for 3 cycles then back high, mode1=11 -> level[1] stays 1, no pulse, edge_cnt1=0.
REQ-037 din[2] toggled 300 times (each hold 8 cycles), mode2=11 -> edge_cnt2 saturates at 255.
REQ-038 clr[3] on same cycle as qualifying edge, irq_en[3]=1 -> pending[3]=1, edge_cnt3=1, irq=1 next cycle.
REQ-039 mode0=00, din[0] toggles -> level[0] follows, no pulse/pending; switch to 01 then 0->1 -> one pulse.
REQ-040 rst asserted 2 cycles into a filter period, din held low -> all outputs reset; after release, pulse 6 edges later, never earlier.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types and default parameters for the multi-channel edge detector.
// Holds the per-channel edge mode encoding, the default parameter set and
// the helper that decides whether a level change counts as an edge.
package edge_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    localparam int unsigned DEF_N_CH        = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_DEB_CYCLES  = 4;
    localparam int unsigned DEF_COUNT_W     = 8;
    localparam logic        DEF_RST_LEVEL   = 1'b1;

    // Debounce counter width; covers DEB_CYCLES up to 2^16-1.
    localparam int unsigned DEB_CNT_W = 16;

    // True when a change to new_level is an edge of interest for mode m.
    function automatic logic edge_qualifies(input edge_mode_e m, input logic new_level);
        logic q;
        q = 1'b0;
        case (m)
            EDGE_RISE: q = new_level;
            EDGE_FALL: q = ~new_level;
            EDGE_BOTH: q = 1'b1;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/edge_ch.sv
// Single edge-detector channel: synchronizer, debounce filter, edge
// qualification, sticky pending flag and saturating edge counter.
// Ports:
//   clk, rst        clock, async active-low reset
//   din             raw asynchronous input
//   mode            edge mode (off / rise / fall / both), sampled with level
//   clr             one-cycle clear of pending and edge_cnt
//   level           debounced level (registered)
//   edge_pulse      one-cycle pulse on a qualifying edge (registered)
//   pending         sticky qualifying-edge flag (registered)
//   edge_cnt        saturating qualifying-edge count (registered)
module edge_ch
    import edge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int unsigned COUNT_W     = DEF_COUNT_W,
    parameter logic        RST_LEVEL   = DEF_RST_LEVEL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic [1:0]         mode,
    input  logic               clr,
    output logic               level,
    output logic               edge_pulse,
    output logic               pending,
    output logic [COUNT_W-1:0] edge_cnt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEB_CNT_W-1:0]   deb_cnt_q;
    logic [DEB_CNT_W-1:0]   deb_cnt_d;
    logic                   sync_out_c;
    logic                   level_d;
    logic                   change_c;
    logic                   qual_c;
    logic                   pending_d;
    logic [COUNT_W-1:0]     edge_cnt_d;

    // Synchronizer chain; only the last stage is used downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {SYNC_STAGES{RST_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Debounce, qualification, pending and counter next-state.
    always_comb begin
        sync_out_c = sync_q[SYNC_STAGES-1];
        deb_cnt_d  = '0;
        level_d    = level;
        change_c   = 1'b0;
        qual_c     = 1'b0;
        pending_d  = pending;
        edge_cnt_d = edge_cnt;

        // Counter only advances while the synchronized value disagrees
        // with level; any agreeing cycle restarts the filter period.
        if (sync_out_c != level) begin
            if (deb_cnt_q == DEB_CNT_W'(DEB_CYCLES - 1)) begin
                change_c = 1'b1;
                level_d  = sync_out_c;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_CNT_W'(1);
            end
        end

        qual_c = change_c & edge_qualifies(edge_mode_e'(mode), sync_out_c);

        // Set wins over clear so a coincident edge is never lost.
        pending_d = qual_c | (pending & ~clr);

        if (clr) begin
            edge_cnt_d = qual_c ? COUNT_W'(1) : '0;
        end else if (qual_c && (edge_cnt != '1)) begin
            edge_cnt_d = edge_cnt + COUNT_W'(1);
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt_q  <= '0;
            level      <= RST_LEVEL;
            edge_pulse <= 1'b0;
            pending    <= 1'b0;
            edge_cnt   <= '0;
        end else begin
            deb_cnt_q  <= deb_cnt_d;
            level      <= level_d;
            edge_pulse <= qual_c;
            pending    <= pending_d;
            edge_cnt   <= edge_cnt_d;
        end
    end

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel debounced edge detector with per-channel mode, sticky
// pending flags, saturating edge counters and a combined interrupt.
// Ports:
//   clk, rst        clock, async active-low reset
//   din[N_CH]       raw asynchronous inputs
//   mode[2*N_CH]    per-channel edge mode, channel i at [2i+1:2i]
//   clr[N_CH]       per-channel clear of pending and edge_cnt
//   irq_en[N_CH]    per-channel interrupt enable
//   level           debounced levels
//   edge_pulse      per-channel qualifying-edge pulses
//   pending         per-channel sticky flags
//   edge_cnt        packed per-channel edge counters
//   irq             registered OR of enabled pending flags
module multi_edge_detector
    import edge_pkg::*;
#(
    parameter int unsigned N_CH        = DEF_N_CH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int unsigned COUNT_W     = DEF_COUNT_W,
    parameter logic        RST_LEVEL   = DEF_RST_LEVEL
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         din,
    input  logic [2*N_CH-1:0]       mode,
    input  logic [N_CH-1:0]         clr,
    input  logic [N_CH-1:0]         irq_en,
    output logic [N_CH-1:0]         level,
    output logic [N_CH-1:0]         edge_pulse,
    output logic [N_CH-1:0]         pending,
    output logic [N_CH*COUNT_W-1:0] edge_cnt,
    output logic                    irq
);

    // Independent channel instances.
    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        edge_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES),
            .COUNT_W     (COUNT_W),
            .RST_LEVEL   (RST_LEVEL)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .din        (din[i]),
            .mode       (mode[2*i+1:2*i]),
            .clr        (clr[i]),
            .level      (level[i]),
            .edge_pulse (edge_pulse[i]),
            .pending    (pending[i]),
            .edge_cnt   (edge_cnt[i*COUNT_W +: COUNT_W])
        );
    end

    // Interrupt follows registered pending one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(pending & irq_en);
        end
    end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector with default parameters.
module tb_multi_edge_detector;

    logic        clk;
    logic        rst;
    logic [3:0]  din;
    logic [7:0]  mode;
    logic [3:0]  clr;
    logic [3:0]  irq_en;
    logic [3:0]  level;
    logic [3:0]  edge_pulse;
    logic [3:0]  pending;
    logic [31:0] edge_cnt;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    multi_edge_detector #(
        .N_CH        (4),
        .SYNC_STAGES (2),
        .DEB_CYCLES  (4),
        .COUNT_W     (8),
        .RST_LEVEL   (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .mode       (mode),
        .clr        (clr),
        .irq_en     (irq_en),
        .level      (level),
        .edge_pulse (edge_pulse),
        .pending    (pending),
        .edge_cnt   (edge_cnt),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b0;
        din    = 4'hF;
        mode   = 8'h00;
        clr    = 4'h0;
        irq_en = 4'h0;
        tick();
        tick();

        // Reset values
        check("rst_level", 32'(level), 32'hF);
        check("rst_pulse", 32'(edge_pulse), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_cnt", edge_cnt, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rst = 1'b1;
        repeat (8) tick();
        check("idle_pulse", 32'(edge_pulse), 32'h0);
        check("idle_level", 32'(level), 32'hF);

        // Ch0 falling edge, mode fall: pulse exactly on the 6th edge
        mode[1:0] = 2'b10;
        din[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("ch0_fall_pulse_k%0d", k), 32'(edge_pulse[0]), (k == 6) ? 32'h1 : 32'h0);
        end
        check("ch0_level", 32'(level[0]), 32'h0);
        check("ch0_pending", 32'(pending[0]), 32'h1);
        check("ch0_cnt", 32'(edge_cnt[7:0]), 32'h1);
        check("irq_masked", 32'(irq), 32'h0);

        // Ch1 3-cycle glitch, mode both: filtered out
        mode[3:2] = 2'b11;
        din[1] = 1'b0;
        repeat (3) tick();
        din[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("ch1_glitch_pulse_k%0d", k), 32'(edge_pulse[1]), 32'h0);
            check($sformatf("ch1_glitch_level_k%0d", k), 32'(level[1]), 32'h1);
        end
        check("ch1_cnt", 32'(edge_cnt[15:8]), 32'h0);
        check("ch1_pending", 32'(pending[1]), 32'h0);

        // Ch3 first edge, then plain clear
        mode[7:6] = 2'b11;
        din[3] = 1'b0;
        repeat (10) tick();
        check("ch3_pend_a", 32'(pending[3]), 32'h1);
        check("ch3_cnt_a", 32'(edge_cnt[31:24]), 32'h1);
        clr[3] = 1'b1;
        tick();
        clr[3] = 1'b0;
        check("ch3_clr_pend", 32'(pending[3]), 32'h0);
        check("ch3_clr_cnt", 32'(edge_cnt[31:24]), 32'h0);

        // Ch3 clear coincident with a qualifying edge
        din[3] = 1'b1;
        repeat (5) tick();
        check("ch3_pre_pulse", 32'(edge_pulse[3]), 32'h0);
        clr[3]    = 1'b1;
        irq_en[3] = 1'b1;
        tick();
        clr[3] = 1'b0;
        check("ch3_coinc_pulse", 32'(edge_pulse[3]), 32'h1);
        check("ch3_coinc_pend", 32'(pending[3]), 32'h1);
        check("ch3_coinc_cnt", 32'(edge_cnt[31:24]), 32'h1);
        check("ch3_irq_not_yet", 32'(irq), 32'h0);
        tick();
        check("ch3_irq", 32'(irq), 32'h1);
        check("ch3_pulse_done", 32'(edge_pulse[3]), 32'h0);

        // Ch2 300 toggles, mode both: counter saturates
        mode[5:4] = 2'b11;
        for (int t = 1; t <= 300; t++) begin
            din[2] = ~din[2];
            repeat (8) tick();
            if (t == 10)  check("ch2_cnt_10", 32'(edge_cnt[23:16]), 32'd10);
            if (t == 255) check("ch2_cnt_255", 32'(edge_cnt[23:16]), 32'd255);
        end
        check("ch2_cnt_sat", 32'(edge_cnt[23:16]), 32'd255);
        check("ch2_level", 32'(level[2]), 32'h1);

        // Ch0 mode off: level tracks, no events; then mode rise
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        check("ch0_clr_pend", 32'(pending[0]), 32'h0);
        mode[1:0] = 2'b00;
        din[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("ch0_off_rise_k%0d", k), 32'(edge_pulse[0]), 32'h0);
        end
        check("ch0_off_level1", 32'(level[0]), 32'h1);
        din[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("ch0_off_fall_k%0d", k), 32'(edge_pulse[0]), 32'h0);
        end
        check("ch0_off_level0", 32'(level[0]), 32'h0);
        check("ch0_off_pend", 32'(pending[0]), 32'h0);
        check("ch0_off_cnt", 32'(edge_cnt[7:0]), 32'h0);
        mode[1:0] = 2'b01;
        tick();
        check("ch0_mode_sw_pulse", 32'(edge_pulse[0]), 32'h0);
        din[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("ch0_rise_k%0d", k), 32'(edge_pulse[0]), (k == 6) ? 32'h1 : 32'h0);
        end
        check("ch0_rise_cnt", 32'(edge_cnt[7:0]), 32'h1);
        check("ch0_rise_pend", 32'(pending[0]), 32'h1);

        // Reset mid-filter discards partial count
        mode[1:0] = 2'b11;
        din[0] = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        check("mid_rst_level", 32'(level), 32'hF);
        check("mid_rst_pulse", 32'(edge_pulse), 32'h0);
        check("mid_rst_pending", 32'(pending), 32'h0);
        check("mid_rst_cnt", edge_cnt, 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        repeat (2) tick();
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("post_rst_pulse_k%0d", k), 32'(edge_pulse[0]), (k == 6) ? 32'h1 : 32'h0);
        end
        check("post_rst_level", 32'(level), 32'hE);
        check("post_rst_cnt", 32'(edge_cnt[7:0]), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
